// File: rtl/me_win_shift_buf.sv
// Search-window shift buffer: a WIN_PIX-pixel window that shifts right by 1..MAX_SHIFT
// pixels per step, refilled from a reserve that is topped up from a small refill FIFO.
module me_win_shift_buf #(
  parameter  int PIX_W     = 8,
  parameter  int WIN_PIX   = 16,
  parameter  int FILL_PIX  = 7,
  parameter  int MAX_SHIFT = 2,
  parameter  int DEPTH     = 4,
  localparam int AMT_W     = $clog2(MAX_SHIFT + 1),
  localparam int CNT_W     = $clog2(2 * FILL_PIX + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        load_i,
  input  logic [WIN_PIX*PIX_W-1:0]    load_data_i,
  input  logic                        fill_valid_i,
  output logic                        fill_ready_o,
  input  logic [FILL_PIX*PIX_W-1:0]   fill_data_i,
  input  logic                        step_valid_i,
  input  logic [AMT_W-1:0]            step_amt_i,
  output logic                        step_ready_o,
  output logic [WIN_PIX*PIX_W-1:0]    win_o,
  output logic                        win_valid_o,
  output logic [CNT_W-1:0]            res_cnt_o
);

  localparam int WIN_W  = WIN_PIX * PIX_W;
  localparam int FILL_W = FILL_PIX * PIX_W;
  localparam int RES_W  = 2 * FILL_PIX * PIX_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;

  // Handshakes: a refill word transfers on fill_valid_i & fill_ready_o, a step on
  // step_valid_i & step_ready_o; both are sampled on the rising clock edge.

  logic [WIN_W-1:0]  win_q, win_d;
  logic [RES_W-1:0]  res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [FILL_W-1:0] mem_q [DEPTH];

  logic                   fifo_empty, fifo_full, push, pop, step_acc, amt_ok;
  logic [CNT_W-1:0]       shift_n, post_cnt;
  logic [RES_W+WIN_W-1:0] shifted;
  logic [RES_W-1:0]       ins_mask, ins_data;
  logic [AW-1:0]          waddr;

  assign fifo_empty   = (wr_q == rd_q);
  assign fifo_full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign fill_ready_o = !fifo_full;
  assign push         = fill_valid_i && !fifo_full;

  assign amt_ok       = (step_amt_i != '0) && (step_amt_i <= AMT_W'(MAX_SHIFT));
  assign step_ready_o = !load_i && amt_ok && (cnt_q >= CNT_W'(step_amt_i));
  assign step_acc     = step_valid_i && step_ready_o;
  assign shift_n      = step_acc ? CNT_W'(step_amt_i) : '0;

  // Reserve sits directly above the window, so one right shift moves both.
  assign shifted  = {res_q, win_q} >> (shift_n * PIX_W);
  assign post_cnt = cnt_q - shift_n;
  assign pop      = !fifo_empty && (post_cnt <= CNT_W'(FILL_PIX));
  assign ins_mask = {{(RES_W-FILL_W){1'b0}}, {FILL_W{1'b1}}} << (post_cnt * PIX_W);
  assign ins_data = {{(RES_W-FILL_W){1'b0}}, mem_q[rd_q[AW-1:0]]} << (post_cnt * PIX_W);
  assign waddr    = load_i ? '0 : wr_q[AW-1:0];

  always_comb begin
    win_d   = win_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (load_i) begin
      // Flush restarts the FIFO at slot 0; a same-cycle push survives there.
      win_d   = load_data_i;
      res_d   = '0;
      cnt_d   = '0;
      valid_d = 1'b1;
      rd_d    = '0;
      wr_d    = push ? PW'(1) : '0;
    end else begin
      win_d   = shifted[WIN_W-1:0];
      res_d   = shifted[WIN_W +: RES_W];
      cnt_d   = post_cnt;
      valid_d = step_acc;
      if (pop) begin
        res_d = (res_d & ~ins_mask) | ins_data;
        cnt_d = post_cnt + CNT_W'(FILL_PIX);
        rd_d  = rd_q + PW'(1);
      end
      if (push) wr_d = wr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      win_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      win_q   <= win_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[waddr] <= fill_data_i;
  end

  assign win_o       = win_q;
  assign win_valid_o = valid_q;
  assign res_cnt_o   = cnt_q;

endmodule

// File: tb/tb_me_win_shift_buf.sv
// Bench for me_win_shift_buf: pixel-queue reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_me_win_shift_buf;

  localparam int PIX_W     = 8;
  localparam int WIN_PIX   = 16;
  localparam int FILL_PIX  = 7;
  localparam int MAX_SHIFT = 2;
  localparam int DEPTH     = 4;
  localparam int WW        = WIN_PIX * PIX_W;
  localparam int FW        = FILL_PIX * PIX_W;
  localparam int AMT_W     = $clog2(MAX_SHIFT + 1);
  localparam int CNT_W     = $clog2(2 * FILL_PIX + 1);

  logic             clk, rst;
  logic             load_i, fill_valid_i, step_valid_i;
  logic [WW-1:0]    load_data_i;
  logic [FW-1:0]    fill_data_i;
  logic [AMT_W-1:0] step_amt_i;
  logic             fill_ready_o, step_ready_o, win_valid_o;
  logic [WW-1:0]    win_o;
  logic [CNT_W-1:0] res_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  me_win_shift_buf dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .load_i       (load_i),
    .load_data_i  (load_data_i),
    .fill_valid_i (fill_valid_i),
    .fill_ready_o (fill_ready_o),
    .fill_data_i  (fill_data_i),
    .step_valid_i (step_valid_i),
    .step_amt_i   (step_amt_i),
    .step_ready_o (step_ready_o),
    .win_o        (win_o),
    .win_valid_o  (win_valid_o),
    .res_cnt_o    (res_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_i       = 1'b0;
    fill_valid_i = 1'b0;
    step_valid_i = 1'b0;
    step_amt_i   = '0;
  endtask

  // ---------------- reference model ----------------
  logic [PIX_W-1:0] m_win [WIN_PIX];
  logic [PIX_W-1:0] m_res [$];
  logic [FW-1:0]    m_fifo [$];
  bit               m_valid;

  function automatic logic [WW-1:0] pack_win();
    logic [WW-1:0] v;
    v = '0;
    for (int i = 0; i < WIN_PIX; i++) v[i*PIX_W +: PIX_W] = m_win[i];
    return v;
  endfunction

  function automatic bit exp_step_ready();
    int n;
    n = int'(step_amt_i);
    return !load_i && n >= 1 && n <= MAX_SHIFT && m_res.size() >= n;
  endfunction

  task automatic model_update();
    int  n;
    bit  acc, push;
    logic [FW-1:0] head;
    if (rst) begin
      for (int i = 0; i < WIN_PIX; i++) m_win[i] = '0;
      m_res.delete();
      m_fifo.delete();
      m_valid = 0;
    end else begin
      n    = int'(step_amt_i);
      acc  = step_valid_i && exp_step_ready();
      push = fill_valid_i && (m_fifo.size() < DEPTH);
      if (load_i) begin
        for (int i = 0; i < WIN_PIX; i++) m_win[i] = load_data_i[i*PIX_W +: PIX_W];
        m_res.delete();
        m_fifo.delete();
        if (push) m_fifo.push_back(fill_data_i);
        m_valid = 1;
      end else begin
        if (acc) begin
          for (int i = 0; i < WIN_PIX - n; i++) m_win[i] = m_win[i+n];
          for (int j = 0; j < n; j++) m_win[WIN_PIX-n+j] = m_res.pop_front();
        end
        if (m_res.size() <= FILL_PIX && m_fifo.size() > 0) begin
          head = m_fifo.pop_front();
          for (int j = 0; j < FILL_PIX; j++) m_res.push_back(head[j*PIX_W +: PIX_W]);
        end
        if (push) m_fifo.push_back(fill_data_i);
        m_valid = acc;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WIN_PIX; i++) m_win[i] = '0;
    m_valid = 0;
    forever begin
      @(posedge clk or posedge rst);
      model_update();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("win_o", win_o, pack_win());
        check("win_valid_o", WW'(win_valid_o), WW'(m_valid));
        check("res_cnt_o", WW'(res_cnt_o), WW'(m_res.size()));
        check("fill_ready_o", WW'(fill_ready_o), WW'(m_fifo.size() < DEPTH));
        check("step_ready_o", WW'(step_ready_o), WW'(exp_step_ready()));
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [WW-1:0] lval;
  logic [63:0]   r64;
  int            pushes;

  initial begin
    rst = 1'b1;
    idle_inputs();
    load_data_i = '0;
    fill_data_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);
    check("rst_win", win_o, '0);
    check("rst_cnt", WW'(res_cnt_o), '0);
    check("rst_fill_ready", WW'(fill_ready_o), WW'(1));
    check("rst_valid", WW'(win_valid_o), '0);

    // Load pixels 0x00..0x0F, one refill word, three single-pixel steps.
    for (int i = 0; i < WIN_PIX; i++) lval[i*PIX_W +: PIX_W] = PIX_W'(i);
    load_i = 1'b1; load_data_i = lval;
    tick();
    load_i = 1'b0; fill_valid_i = 1'b1; fill_data_i = 56'h16_15_14_13_12_11_10;
    tick();
    fill_valid_i = 1'b0;
    tick();
    @(negedge clk);
    check("t2_cnt7", WW'(res_cnt_o), WW'(7));
    step_valid_i = 1'b1; step_amt_i = 2'd1;
    tick();
    @(negedge clk);
    check("t2_pix15_a", WW'(win_o[127:120]), WW'(8'h10));
    check("t2_valid", WW'(win_valid_o), WW'(1));
    tick();
    tick();
    step_valid_i = 1'b0;
    @(negedge clk);
    check("t2_top3", WW'(win_o[127:104]), WW'(24'h12_11_10));
    check("t2_pix0", WW'(win_o[7:0]), WW'(8'h03));
    check("t2_cnt4", WW'(res_cnt_o), WW'(4));

    // Starvation: drain to one reserve pixel, then ask for two.
    step_valid_i = 1'b1; step_amt_i = 2'd2;
    tick();
    step_amt_i = 2'd1;
    tick();
    step_amt_i = 2'd2;
    @(negedge clk);
    check("t5_cnt1", WW'(res_cnt_o), WW'(1));
    check("t5_blocked_a", WW'(step_ready_o), '0);
    tick();
    tick();
    fill_valid_i = 1'b1; fill_data_i = 56'h37_36_35_34_33_32_31;
    @(negedge clk);
    check("t5_blocked_b", WW'(step_ready_o), '0);
    tick();
    fill_valid_i = 1'b0;
    @(negedge clk);
    check("t5_no_fallthru", WW'(res_cnt_o), WW'(1));
    tick();
    @(negedge clk);
    check("t5_ready", WW'(step_ready_o), WW'(1));
    check("t5_cnt8", WW'(res_cnt_o), WW'(8));
    tick();
    step_valid_i = 1'b0;
    @(negedge clk);
    check("t5_cnt6", WW'(res_cnt_o), WW'(6));
    check("t5_top2", WW'(win_o[127:112]), WW'(16'h31_16));

    // Leave a stale word in the FIFO, then load with step and push pending.
    fill_valid_i = 1'b1; fill_data_i = 56'h4A_4A_4A_4A_4A_4A_4A;
    tick();
    fill_data_i = 56'h5B_5B_5B_5B_5B_5B_5B;
    tick();
    for (int i = 0; i < WIN_PIX; i++) lval[i*PIX_W +: PIX_W] = PIX_W'(8'hE0 + i);
    load_i = 1'b1; load_data_i = lval;
    step_valid_i = 1'b1; step_amt_i = 2'd1;
    fill_data_i = 56'h66_55_44_33_22_11_A0;
    @(negedge clk);
    check("t6_step_blocked", WW'(step_ready_o), '0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("t6_win", win_o, lval);
    check("t6_cnt0", WW'(res_cnt_o), '0);
    tick();
    @(negedge clk);
    check("t6_cnt7", WW'(res_cnt_o), WW'(7));
    step_valid_i = 1'b1; step_amt_i = 2'd1;
    tick();
    step_valid_i = 1'b0;
    @(negedge clk);
    check("t6_pix15", WW'(win_o[127:120]), WW'(8'hA0));
    check("t6_pix0", WW'(win_o[7:0]), WW'(8'hE1));

    // FIFO fill after load: two words drain into the reserve, four stay queued.
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    pushes = 0;
    for (int k = 0; k < 10; k++) begin
      fill_valid_i = 1'b1;
      r64 = {$urandom, $urandom};
      fill_data_i = r64[FW-1:0];
      @(negedge clk);
      if (!fill_ready_o) break;
      pushes++;
      tick();
    end
    fill_valid_i = 1'b0;
    check("t4_pushes", WW'(pushes), WW'(6));
    check("t4_cnt14", WW'(res_cnt_o), WW'(14));
    check("t4_full", WW'(fill_ready_o), '0);

    // Reset in the middle of traffic.
    fill_valid_i = 1'b1; step_valid_i = 1'b1; step_amt_i = 2'd2;
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t1_win", win_o, '0);
    check("t1_cnt", WW'(res_cnt_o), '0);
    check("t1_fill_ready", WW'(fill_ready_o), WW'(1));
    check("t1_valid", WW'(win_valid_o), '0);
    tick();
    rst = 1'b0;
    idle_inputs();

    // Randomized traffic against the model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      load_i = ($urandom_range(0, 40) == 0);
      load_data_i = {$urandom, $urandom, $urandom, $urandom};
      fill_valid_i = ($urandom_range(0, 2) != 0);
      r64 = {$urandom, $urandom};
      fill_data_i = r64[FW-1:0];
      step_valid_i = ($urandom_range(0, 3) != 0);
      step_amt_i = AMT_W'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end
    idle_inputs();
    tick();
    @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
